// File: rtl/fifo_scan_param.sv
// fifo_scan_param: parametrised circular FIFO driven by raw button levels,
// with occupancy flags, overflow/underflow pulses and a scanned digit display.
module fifo_btn_pulse (
    input  logic clk,
    input  logic rst,
    input  logic lvl_i,
    output logic pulse_o
);
    logic s1_q;
    logic s2_q;
    logic s3_q;

    // Two-stage synchroniser plus delay stage for rising-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= lvl_i;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign pulse_o = s2_q & ~s3_q;
endmodule

module fifo_scan_param #(
    parameter  int WIDTH    = 4,
    parameter  int DEPTH    = 8,
    parameter  int AF_LEVEL = 6,
    parameter  int SCAN_DIV = 250000,
    localparam int AW       = $clog2(DEPTH),
    localparam int CW       = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enq,
    input  logic             deq,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow,
    output logic [AW-1:0]    an,
    output logic [WIDTH-1:0] seg,
    output logic             disp_en
);
    localparam int DVW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    logic             p;
    logic             q;

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]    wp_q,    wp_d;
    logic [AW-1:0]    rp_q,    rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] out_q,   out_d;
    logic             ovf_q,   ovf_d;
    logic             unf_q,   unf_d;

    logic [DVW-1:0]   div_q,   div_d;
    logic [AW-1:0]    dig_q,   dig_d;
    logic [AW-1:0]    an_q,    an_d;
    logic [WIDTH-1:0] seg_q,   seg_d;
    logic             den_q,   den_d;

    logic             full_w;
    logic             empty_w;
    logic             push_ok;
    logic             pop_ok;
    logic             tick;
    logic [AW-1:0]    scan_addr;

    fifo_btn_pulse u_enq (
        .clk     (clk),
        .rst     (rst),
        .lvl_i   (enq),
        .pulse_o (p)
    );

    fifo_btn_pulse u_deq (
        .clk     (clk),
        .rst     (rst),
        .lvl_i   (deq),
        .pulse_o (q)
    );

    assign full_w  = (count_q == CW'(DEPTH));
    assign empty_w = (count_q == '0);

    // Queue next-state: a full queue still accepts a push paired with a pop
    always_comb begin
        push_ok = p && (!full_w || q);
        pop_ok  = q && !empty_w;
        wp_d    = push_ok ? wp_q + AW'(1) : wp_q;
        rp_d    = pop_ok ? rp_q + AW'(1) : rp_q;
        count_d = count_q;
        unique case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        out_d = pop_ok ? mem_q[rp_q] : out_q;
        ovf_d = p && full_w && !q;
        unf_d = q && empty_w;
    end

    // Display scan next-state: load the current digit, then advance
    always_comb begin
        tick      = (div_q == DVW'(SCAN_DIV - 1));
        scan_addr = rp_q + dig_q;
        div_d     = tick ? '0 : div_q + DVW'(1);
        dig_d     = dig_q;
        an_d      = an_q;
        seg_d     = seg_q;
        den_d     = den_q;
        if (tick) begin
            dig_d = dig_q + AW'(1);
            an_d  = dig_q;
            seg_d = mem_q[scan_addr];
            den_d = ({1'b0, dig_q} < count_q);
        end
    end

    // Storage is never cleared; the count gates everything that reads it
    always_ff @(posedge clk) begin
        if (!rst && push_ok) begin
            mem_q[wp_q] <= in;
        end
    end

    // Queue control registers
    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            out_q   <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            out_q   <= out_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Scan divider, digit index and display registers
    always_ff @(posedge clk) begin
        if (rst) begin
            div_q <= '0;
            dig_q <= '0;
            an_q  <= '0;
            seg_q <= '0;
            den_q <= 1'b0;
        end else begin
            div_q <= div_d;
            dig_q <= dig_d;
            an_q  <= an_d;
            seg_q <= seg_d;
            den_q <= den_d;
        end
    end

    assign out         = out_q;
    assign count       = count_q;
    assign full        = full_w;
    assign empty       = empty_w;
    assign almost_full = (count_q >= CW'(AF_LEVEL));
    assign overflow    = ovf_q;
    assign underflow   = unf_q;
    assign an          = an_q;
    assign seg         = seg_q;
    assign disp_en     = den_q;
endmodule

// File: tb/tb_fifo_scan_param.sv
// tb_fifo_scan_param: directed and random checks of fifo_scan_param
// against a queue-based reference model.
module tb_fifo_scan_param;
    localparam int WIDTH = 4;
    localparam int DEPTH = 8;
    localparam int AFL   = 6;
    localparam int SDIV  = 4;
    localparam int AW    = 3;
    localparam int CW    = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             enq = 1'b0;
    logic             deq = 1'b0;
    logic [WIDTH-1:0] in  = '0;
    logic [WIDTH-1:0] out;
    logic             full;
    logic             empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;
    logic [AW-1:0]    an;
    logic [WIDTH-1:0] seg;
    logic             disp_en;

    int checks = 0;
    int errors = 0;

    int          mq[$];
    logic [3:0]  out_m = '0;
    bit          ovf_m;
    bit          unf_m;

    fifo_scan_param #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .AF_LEVEL (AFL),
        .SCAN_DIV (SDIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enq         (enq),
        .deq         (deq),
        .in          (in),
        .out         (out),
        .full        (full),
        .empty       (empty),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow),
        .an          (an),
        .seg         (seg),
        .disp_en     (disp_en)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_apply(input bit e, input bit d, input int v);
        int  n;
        bit  was_full;
        bit  was_empty;
        n         = mq.size();
        was_full  = (n == DEPTH);
        was_empty = (n == 0);
        ovf_m     = 0;
        unf_m     = 0;
        if (d && !was_empty) out_m = 4'(mq.pop_front());
        if (d && was_empty) unf_m = 1;
        if (e && (!was_full || d)) mq.push_back(v);
        if (e && was_full && !d) ovf_m = 1;
    endtask

    task automatic chk_state(input string tag);
        chk({tag, ".count"}, 32'(count), 32'(mq.size()));
        chk({tag, ".full"}, 32'(full), 32'(mq.size() == DEPTH));
        chk({tag, ".empty"}, 32'(empty), 32'(mq.size() == 0));
        chk({tag, ".af"}, 32'(almost_full), 32'(mq.size() >= AFL));
        chk({tag, ".out"}, 32'(out), 32'(out_m));
    endtask

    task automatic op(input string tag, input bit e, input bit d,
                      input int v);
        @(negedge clk);
        enq = e;
        deq = d;
        in  = 4'(v);
        repeat (3) @(posedge clk);
        #1;
        model_apply(e, d, v);
        chk_state(tag);
        chk({tag, ".ovf"}, 32'(overflow), 32'(ovf_m));
        chk({tag, ".unf"}, 32'(underflow), 32'(unf_m));
        @(posedge clk);
        #1;
        chk({tag, ".ovf_end"}, 32'(overflow), 32'd0);
        chk({tag, ".unf_end"}, 32'(underflow), 32'd0);
        @(negedge clk);
        enq = 0;
        deq = 0;
        repeat (3) @(posedge clk);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1;
        @(posedge clk);
        #1;
        mq.delete();
        out_m = '0;
        chk_state(tag);
        chk({tag, ".ovf"}, 32'(overflow), 32'd0);
        chk({tag, ".unf"}, 32'(underflow), 32'd0);
        chk({tag, ".an"}, 32'(an), 32'd0);
        chk({tag, ".seg"}, 32'(seg), 32'd0);
        chk({tag, ".den"}, 32'(disp_en), 32'd0);
        @(negedge clk);
        rst = 0;
    endtask

    initial begin
        int          base;
        int          changes;
        logic [7:0]  seen;
        logic [2:0]  prev_an;
        int          e;
        int          d;

        // Power-on reset
        @(negedge clk);
        rst = 1;
        repeat (2) @(posedge clk);
        do_reset("reset");

        // Fill 1..8, then overflow
        for (int i = 1; i <= 8; i++) op("fill", 1, 0, i);
        op("overflow", 1, 0, 9);

        // Drain 1..8, then underflow
        for (int i = 1; i <= 8; i++) op("drain", 0, 1, 0);
        op("underflow", 0, 1, 0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) op("wrap_push", 1, 0, 10 + i);
        for (int i = 0; i < 3; i++) op("wrap_pop", 0, 1, 0);
        for (int i = 0; i < 6; i++) op("wrap_push2", 1, 0, i + 1);
        for (int i = 0; i < 8; i++) op("wrap_drain", 0, 1, 0);

        // Simultaneous push/pop while empty, then while full
        op("sim_empty", 1, 1, 4'hA);
        for (int i = 0; i < 7; i++) op("sim_fill", 1, 0, 2 + i);
        op("sim_full", 1, 1, 4'h5);
        for (int i = 0; i < 8; i++) op("sim_drain", 0, 1, 0);

        // Held level produces exactly one push, two edges after the rise
        do_reset("reset2");
        @(negedge clk);
        enq = 1;
        in  = 4'h7;
        @(posedge clk);
        #1;
        chk("hold.k", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        chk("hold.k1", 32'(count), 32'd0);
        @(posedge clk);
        #1;
        model_apply(1, 0, 7);
        chk_state("hold.k2");
        repeat (47) @(posedge clk);
        #1;
        chk("hold.end", 32'(count), 32'(mq.size()));
        chk("hold.ovf", 32'(overflow), 32'd0);
        @(negedge clk);
        enq = 0;
        repeat (3) @(posedge clk);

        // Display scan with three entries
        do_reset("reset3");
        op("scan_push", 1, 0, 4'hB);
        op("scan_push", 1, 0, 4'hC);
        op("scan_push", 1, 0, 4'hD);
        repeat (DEPTH * SDIV + 8) @(posedge clk);
        #1;
        changes = 0;
        seen    = '0;
        prev_an = an;
        for (int c = 0; c < DEPTH * SDIV; c++) begin
            @(posedge clk);
            #1;
            if (an !== prev_an) begin
                changes++;
                chk("scan.step", 32'(an), 32'(3'(prev_an + 3'd1)));
            end
            prev_an = an;
            seen[an] = 1'b1;
            chk("scan.den", 32'(disp_en), 32'(int'(an) < mq.size()));
            if (int'(an) < mq.size())
                chk("scan.seg", 32'(seg), 32'(mq[an]));
        end
        chk("scan.changes", 32'(changes), 32'(DEPTH));
        chk("scan.seen", 32'(seen), 32'hFF);
        repeat (2) @(posedge clk);
        do_reset("scan_rst");

        // Random push/pop sequence
        base = 0;
        for (int i = 0; i < 80; i++) begin
            e = int'($urandom_range(0, 2));
            d = (e == 0) ? 1 : int'($urandom_range(0, 1));
            if (e == 2) e = 1;
            base = int'($urandom_range(0, 15));
            op("rand", e[0], d[0], base);
        end
        while (mq.size() > 0) op("rand_drain", 0, 1, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks,
                 errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end
endmodule
